// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR-sample UART transmitter.
// The frame is 8N1: one start bit, DATA_BITS data bits, one stop bit.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_e;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;
  localparam int BIT_CNT_W  = 12;
  localparam int BIT_IDX_W  = $clog2(DATA_BITS);

endpackage

// File: rtl/fir_sync_fifo.sv
// Small synchronous FIFO buffering FIR samples ahead of the UART.
// A push on a full FIFO is still accepted when a pop happens on the same edge.
module fir_sync_fifo
  import fir_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_BITS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [3:0]       level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [3:0]       level_q, level_d;
  logic             pushEn;
  logic             popEn;

  assign full_o  = (level_q == 4'(DEPTH));
  assign empty_o = (level_q == 4'd0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rdPtr_q];

  assign popEn  = pop_i && !empty_o;
  assign pushEn = push_i && (!full_o || popEn);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (pushEn) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (popEn)  rdPtr_d = rdPtr_q + PTR_W'(1);
    case ({pushEn, popEn})
      2'b10:   level_d = level_q + 4'd1;
      2'b01:   level_d = level_q - 4'd1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: the pointers and level decide what is valid.
  always_ff @(posedge clk_i) begin
    if (pushEn) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/fir_uart_tx.sv
// Streams buffered FIR output samples onto an 8N1 UART line.
// tx comes straight from a flop; a frame starts on the edge after a sample lands.
module fir_uart_tx
  import fir_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  input  logic       ovf_clr,
  output logic       tx,
  output logic       busy,
  output logic       overflow,
  output logic [3:0] fifo_level
);

  localparam logic [BIT_CNT_W-1:0] CNT_LAST = BIT_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(DATA_BITS - 1);

  txState_e               state_q, state_d;
  logic [BIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0]   bitIdx_q, bitIdx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   overflow_q, overflow_d;
  logic                   pop;
  logic                   bitEnd;
  logic                   drop;
  logic [DATA_BITS-1:0]   fifoHead;
  logic                   fifoFull;
  logic                   fifoEmpty;

  fir_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (sample_valid),
    .wdata_i (sample_in),
    .pop_i   (pop),
    .rdata_o (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .level_o (fifo_level)
  );

  assign bitEnd = (cnt_q == CNT_LAST);
  assign drop   = sample_valid && fifoFull && !pop;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        bitIdx_d = '0;
        tx_d     = 1'b1;
        if (!fifoEmpty) begin
          pop     = 1'b1;
          shift_d = fifoHead;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bitEnd) begin
          cnt_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b1, shift_q[DATA_BITS-1:1]};
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + BIT_CNT_W'(1);
        end
      end
      DATA: begin
        if (bitEnd) begin
          cnt_d = '0;
          // shift_q[0] already holds the next bit, so it can be loaded into tx directly.
          if (bitIdx_q == IDX_LAST) begin
            bitIdx_d = '0;
            tx_d     = 1'b1;
            state_d  = STOP;
          end else begin
            bitIdx_d = bitIdx_q + BIT_IDX_W'(1);
            tx_d     = shift_q[0];
            shift_d  = {1'b1, shift_q[DATA_BITS-1:1]};
          end
        end else begin
          cnt_d = cnt_q + BIT_CNT_W'(1);
        end
      end
      STOP: begin
        if (bitEnd) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + BIT_CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // A drop on the same edge as ovf_clr keeps the flag set.
  assign overflow_d = drop || (overflow_q && !ovf_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fir_uart_tx.sv
// Directed bench for fir_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fir_uart_tx;
  import fir_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sampleIn = 8'h00;
  logic       sampleValid = 1'b0;
  logic       ovfClr = 1'b0;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [3:0] fifoLevel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fir_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sampleIn),
    .sample_valid (sampleValid),
    .ovf_clr      (ovfClr),
    .tx           (tx),
    .busy         (busy),
    .overflow     (overflow),
    .fifo_level   (fifoLevel)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic clr);
    sampleValid = v;
    sampleIn    = d;
    ovfClr      = clr;
  endtask

  // Checks the rest of a frame from startCycle, then the single idle cycle after it.
  task automatic checkFrame(input string tag, input logic [7:0] data, input int startCycle);
    logic [FRAME_BITS-1:0] frame;
    frame = {1'b1, data, 1'b0};
    for (int k = startCycle; k < FRAME_BITS * CPB; k++) begin
      checkOutput($sformatf("%s cyc%0d tx", tag, k), tx, frame[k / CPB]);
      checkOutput($sformatf("%s cyc%0d busy", tag, k), busy, 1);
      step();
    end
    checkOutput({tag, " idle busy"}, busy, 0);
    checkOutput({tag, " idle tx"}, tx, 1);
  endtask

  // Waits for any running frame to finish and the next one to begin.
  task automatic waitFrameStart(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 400) begin
      step();
      n++;
    end
    while (busy !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    checkOutput({tag, " start seen"}, (n < 400) ? 1 : 0, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;

    applyStimulus(0, 8'h00, 0);
    rst_n = 1'b0;
    repeat (3) step();
    checkOutput("rst tx", tx, 1);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst overflow", overflow, 0);
    checkOutput("rst level", fifoLevel, 0);

    // Single sample pushed on the very first edge after reset release.
    rst_n = 1'b1;
    applyStimulus(1, 8'hA5, 0);
    step();
    checkOutput("t1 level", fifoLevel, 1);
    checkOutput("t1 tx before", tx, 1);
    applyStimulus(0, 8'h00, 0);
    step();
    checkOutput("t1 level popped", fifoLevel, 0);
    checkFrame("t1", 8'hA5, 0);
    step();
    checkOutput("t1 stays idle", busy, 0);

    // Burst of three consecutive samples.
    applyStimulus(1, 8'h01, 0);
    step();
    checkOutput("t2 level e1", fifoLevel, 1);
    checkOutput("t2 tx e1", tx, 1);
    applyStimulus(1, 8'h02, 0);
    step();
    checkOutput("t2 level e2", fifoLevel, 1);
    checkOutput("t2 tx e2", tx, 0);
    applyStimulus(1, 8'h03, 0);
    step();
    checkOutput("t2 level peak", fifoLevel, 2);
    applyStimulus(0, 8'h00, 0);
    checkFrame("t2a", 8'h01, 1);
    step();
    checkOutput("t2 level after pop2", fifoLevel, 1);
    checkFrame("t2b", 8'h02, 0);
    step();
    checkOutput("t2 level after pop3", fifoLevel, 0);
    checkFrame("t2c", 8'h03, 0);
    step();
    checkOutput("t2 no fourth frame", busy, 0);

    // Overflow: six pushes while a frame runs with an empty FIFO.
    applyStimulus(1, 8'h55, 0);
    step();
    applyStimulus(0, 8'h00, 0);
    step();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 8'(8'h10 + i), 0);
      step();
    end
    applyStimulus(0, 8'h00, 0);
    checkOutput("t3 level full", fifoLevel, 4);
    checkOutput("t3 overflow set", overflow, 1);
    repeat (5) step();
    checkOutput("t3 overflow sticky", overflow, 1);
    applyStimulus(0, 8'h00, 1);
    step();
    applyStimulus(0, 8'h00, 0);
    checkOutput("t3 overflow cleared", overflow, 0);
    applyStimulus(1, 8'h77, 1);
    step();
    applyStimulus(0, 8'h00, 0);
    checkOutput("t3 clr vs drop", overflow, 1);
    checkOutput("t3 level after drop", fifoLevel, 4);
    applyStimulus(0, 8'h00, 1);
    step();
    applyStimulus(0, 8'h00, 0);
    checkOutput("t3 overflow cleared again", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      waitFrameStart($sformatf("t3 d%0d", i));
      checkFrame($sformatf("t3 d%0d", i), 8'(8'h10 + i), 0);
    end
    step();
    checkOutput("t3 drained level", fifoLevel, 0);
    checkOutput("t3 drained busy", busy, 0);

    // Push on the pop edge with the FIFO full in IDLE.
    applyStimulus(1, 8'h55, 0);
    step();
    applyStimulus(0, 8'h00, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 8'(8'h20 + i), 0);
      step();
    end
    applyStimulus(0, 8'h00, 0);
    checkOutput("t4 level full", fifoLevel, 4);
    checkFrame("t4 head", 8'h55, 4);
    checkOutput("t4 idle level", fifoLevel, 4);
    applyStimulus(1, 8'h24, 0);
    step();
    applyStimulus(0, 8'h00, 0);
    checkOutput("t4 level push+pop", fifoLevel, 4);
    checkOutput("t4 no overflow", overflow, 0);
    checkOutput("t4 tx start", tx, 0);
    checkFrame("t4 f0", 8'h20, 0);
    for (int i = 1; i < 5; i++) begin
      step();
      checkFrame($sformatf("t4 f%0d", i), 8'(8'h20 + i), 0);
    end
    step();
    checkOutput("t4 drained level", fifoLevel, 0);
    checkOutput("t4 drained busy", busy, 0);

    // Reset during DATA bit 3 of 0x00 with another sample queued.
    applyStimulus(1, 8'h00, 0);
    step();
    applyStimulus(1, 8'h33, 0);
    step();
    applyStimulus(0, 8'h00, 0);
    checkOutput("t5 queued level", fifoLevel, 1);
    repeat (17) step();
    checkOutput("t5 data bit3 tx", tx, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5 async tx", tx, 1);
    checkOutput("t5 async busy", busy, 0);
    checkOutput("t5 async level", fifoLevel, 0);
    step();
    step();
    rst_n = 1'b1;
    seen = 0;
    repeat (60) begin
      step();
      if (busy) seen++;
    end
    checkOutput("t5 no frame after reset", seen, 0);
    checkOutput("t5 level after reset", fifoLevel, 0);
    checkOutput("t5 tx idle", tx, 1);
    applyStimulus(1, 8'h3C, 0);
    step();
    applyStimulus(0, 8'h00, 0);
    step();
    checkFrame("t5 new", 8'h3C, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
